// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: both master ports plus the shared memory port.
// The slave modport is the arbiter's view; master is the view of the surrounding masters and memory.
interface mem_arbiter_if #(
  parameter int M = 16,
  parameter int N = 32
);
  logic [N-1:0] m0Addr;
  logic [M-1:0] m0WData;
  logic         m0RE;
  logic         m0WE;
  logic [M-1:0] m0RData;
  logic         m0Ready;

  logic [N-1:0] m1Addr;
  logic [M-1:0] m1WData;
  logic         m1RE;
  logic         m1WE;
  logic         m1Lock;
  logic [M-1:0] m1RData;
  logic         m1Ready;

  logic [N-1:0] memAddr;
  logic [M-1:0] memWrite;
  logic         memRE;
  logic         memWE;
  logic [M-1:0] memRead;
  logic         memAck;
  logic         busErr;

  modport master (
    output m0Addr, m0WData, m0RE, m0WE,
    output m1Addr, m1WData, m1RE, m1WE, m1Lock,
    output memRead, memAck,
    input  m0RData, m0Ready, m1RData, m1Ready,
    input  memAddr, memWrite, memRE, memWE, busErr
  );

  modport slave (
    input  m0Addr, m0WData, m0RE, m0WE,
    input  m1Addr, m1WData, m1RE, m1WE, m1Lock,
    input  memRead, memAck,
    output m0RData, m0Ready, m1RData, m1Ready,
    output memAddr, memWrite, memRE, memWE, busErr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-master memory arbiter with an acknowledge watchdog.
// Optional locked bursts for master 1 are enabled by defining MEM_ARB_BURST_EN.
module mem_arbiter #(
  parameter int M         = 16,
  parameter int N         = 32,
  parameter int TIMEOUT   = 255,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [15:0]  wd_cnt_q, wd_cnt_d;

`ifdef MEM_ARB_BURST_EN
  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
`else
  logic unused_lock_s;
  assign unused_lock_s = bus.m1Lock;
`endif

  logic         req0_s, req1_s, sel_s, req_sel_s;
  logic [N-1:0] mem_addr_s;
  logic [M-1:0] mem_write_s, rdata_s;
  logic         mem_re_s, mem_we_s, ready_s, bus_err_s;

  assign req0_s    = bus.m0RE | bus.m0WE;
  assign req1_s    = bus.m1RE | bus.m1WE;
  assign sel_s     = (state_q == GRANT1);
  assign req_sel_s = sel_s ? req1_s : req0_s;

  // Next state, counters and the combinational memory-side mux
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = wd_cnt_q;
`ifdef MEM_ARB_BURST_EN
    burst_cnt_d  = burst_cnt_q;
`endif
    mem_addr_s   = '0;
    mem_write_s  = '0;
    mem_re_s     = 1'b0;
    mem_we_s     = 1'b0;
    rdata_s      = '0;
    ready_s      = 1'b0;
    bus_err_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_s && req1_s) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (req0_s) begin
          state_d = GRANT0;
        end else if (req1_s) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT0, GRANT1: begin
        mem_addr_s  = sel_s ? bus.m1Addr  : bus.m0Addr;
        mem_write_s = sel_s ? bus.m1WData : bus.m0WData;
        mem_re_s    = sel_s ? bus.m1RE    : bus.m0RE;
        mem_we_s    = sel_s ? bus.m1WE    : bus.m0WE;
        rdata_s     = bus.memRead;

        if (!req_sel_s) begin
          state_d      = IDLE;
          last_grant_d = sel_s;
          wd_cnt_d     = 16'd0;
`ifdef MEM_ARB_BURST_EN
          burst_cnt_d  = '0;
`endif
        end else if (bus.memAck) begin
          ready_s      = 1'b1;
          last_grant_d = sel_s;
          wd_cnt_d     = 16'd0;
`ifdef MEM_ARB_BURST_EN
          // A locked master 1 keeps the grant until its burst allowance is used
          if (sel_s && bus.m1Lock && (burst_cnt_q < BURST_LAST)) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end else begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end
`else
          state_d      = IDLE;
`endif
        end else if (wd_cnt_q == WD_LAST) begin
          ready_s      = 1'b1;
          rdata_s      = '0;
          bus_err_s    = 1'b1;
          state_d      = IDLE;
          last_grant_d = sel_s;
          wd_cnt_d     = 16'd0;
`ifdef MEM_ARB_BURST_EN
          burst_cnt_d  = '0;
`endif
        end else begin
          wd_cnt_d     = wd_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= 16'd0;
`ifdef MEM_ARB_BURST_EN
      burst_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
`ifdef MEM_ARB_BURST_EN
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  assign bus.memAddr  = mem_addr_s;
  assign bus.memWrite = mem_write_s;
  assign bus.memRE    = mem_re_s;
  assign bus.memWE    = mem_we_s;
  assign bus.busErr   = bus_err_s;
  assign bus.m0Ready  = ready_s & (state_q == GRANT0);
  assign bus.m1Ready  = ready_s & (state_q == GRANT1);
  assign bus.m0RData  = (state_q == GRANT0) ? rdata_s : '0;
  assign bus.m1RData  = (state_q == GRANT1) ? rdata_s : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle plus literal expectations.
// Built with TIMEOUT=4; the burst test expectation follows MEM_ARB_BURST_EN.
module tb_mem_arbiter;
  localparam int M  = 16;
  localparam int N  = 32;
  localparam int TO = 4;
  localparam int BM = 8;
`ifdef MEM_ARB_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.M(M), .N(N)) bus ();
  mem_arbiter #(.M(M), .N(N), .TIMEOUT(TO), .BURST_MAX(BM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the memory (-1 = nobody), who was served last, cycles waited, transfers in burst
  logic [1:0] req_v;
  assign req_v = {bus.m1RE | bus.m1WE, bus.m0RE | bus.m0WE};
  int owner  = -1;
  int last   = 1;
  int waited = 0;
  int bursts = 0;

  always @(posedge clk) begin
    if (rst) begin
      owner = -1; last = 1; waited = 0; bursts = 0;
    end else if (owner < 0) begin
      if (req_v == 2'b11)      owner = 1 - last;
      else if (req_v[0])       owner = 0;
      else if (req_v[1])       owner = 1;
    end else if (!req_v[owner]) begin
      last = owner; owner = -1; waited = 0; bursts = 0;
    end else if (bus.memAck) begin
      last = owner; waited = 0;
      if (owner == 1 && BURST_ON && bus.m1Lock && bursts < BM - 1) bursts++;
      else begin owner = -1; bursts = 0; end
    end else if (waited == TO - 1) begin
      last = owner; owner = -1; waited = 0; bursts = 0;
    end else begin
      waited++;
    end
  end

  // Every cycle: DUT outputs against what the model says the owner should see
  always @(negedge clk) begin
    if (run) begin
      if (owner < 0) begin
        chk("m_addr", bus.memAddr, 64'd0);
        chk("m_wdata", bus.memWrite, 64'd0);
        chk("m_re", bus.memRE, 64'd0);
        chk("m_we", bus.memWE, 64'd0);
        chk("m_rdy0", bus.m0Ready, 64'd0);
        chk("m_rdy1", bus.m1Ready, 64'd0);
        chk("m_rd0", bus.m0RData, 64'd0);
        chk("m_rd1", bus.m1RData, 64'd0);
        chk("m_err", bus.busErr, 64'd0);
      end else begin
        automatic bit x    = (owner == 1);
        automatic bit tout = req_v[owner] && !bus.memAck && (waited == TO - 1);
        automatic bit fin  = req_v[owner] && (bus.memAck || waited == TO - 1);
        automatic logic [M-1:0] rd = tout ? 16'h0000 : bus.memRead;
        chk("m_addr", bus.memAddr, x ? bus.m1Addr : bus.m0Addr);
        chk("m_wdata", bus.memWrite, x ? bus.m1WData : bus.m0WData);
        chk("m_re", bus.memRE, x ? bus.m1RE : bus.m0RE);
        chk("m_we", bus.memWE, x ? bus.m1WE : bus.m0WE);
        chk("m_rdy0", bus.m0Ready, !x && fin);
        chk("m_rdy1", bus.m1Ready, x && fin);
        chk("m_rd0", bus.m0RData, x ? 16'h0000 : rd);
        chk("m_rd1", bus.m1RData, x ? rd : 16'h0000);
        chk("m_err", bus.busErr, tout);
      end
    end
  end

  task automatic clr();
    bus.m0Addr = '0; bus.m0WData = '0; bus.m0RE = 1'b0; bus.m0WE = 1'b0;
    bus.m1Addr = '0; bus.m1WData = '0; bus.m1RE = 1'b0; bus.m1WE = 1'b0; bus.m1Lock = 1'b0;
    bus.memRead = '0; bus.memAck = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1; clr();
    cyc(); rst = 1'b0;
  endtask

  initial begin
    int c0, c1, held, r0, r1;
    logic [9:0] p0, p1;
    clr();
    rst = 1'b1;
    cyc();
    run = 1'b1;

    // Single read, memory acknowledges immediately
    do_reset();
    bus.m0RE = 1'b1; bus.m0Addr = 32'h0000_1234; bus.memAck = 1'b1; bus.memRead = 16'hBEEF;
    @(negedge clk); chk("t1_idle_re", bus.memRE, 64'd0);
    cyc();
    @(negedge clk);
    chk("t1_re", bus.memRE, 64'd1);
    chk("t1_addr", bus.memAddr, 64'h1234);
    chk("t1_ready", bus.m0Ready, 64'd1);
    chk("t1_rdata", bus.m0RData, 64'hBEEF);
    cyc(); bus.m0RE = 1'b0;
    @(negedge clk);
    chk("t1_back_idle", bus.memRE, 64'd0);
    chk("t1_no_ready", bus.m0Ready, 64'd0);

    // Both masters requesting continuously with memAck high
    do_reset();
    bus.memAck = 1'b1; bus.m0RE = 1'b1; bus.m1RE = 1'b1;
    bus.m0Addr = 32'h0000_0100; bus.m1Addr = 32'h0000_0200;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c0 += int'(bus.m0Ready); c1 += int'(bus.m1Ready);
      if (i == 1) chk("t2_first_m0", bus.m0Ready, 64'd1);
      if (i == 3) chk("t2_then_m1", bus.m1Ready, 64'd1);
      cyc();
    end
    chk("t2_m0_count", c0, 64'd4);
    chk("t2_m1_count", c1, 64'd4);

    // Master 1 write with a 3-cycle acknowledge delay; master 0 waits
    do_reset();
    bus.m1WE = 1'b1; bus.m1WData = 16'h5A5A; bus.m1Addr = 32'hABCD_0000;
    cyc();
    bus.m0RE = 1'b1; bus.m0Addr = 32'h0000_0042;
    held = 0; r0 = 0; r1 = 0;
    for (int k = 1; k <= 4; k++) begin
      bus.memAck = (k == 4);
      @(negedge clk);
      if (bus.memWE && bus.memWrite == 16'h5A5A) held++;
      r0 += int'(bus.m0Ready); r1 += int'(bus.m1Ready);
      if (k == 4) chk("t3_ack_ready", bus.m1Ready, 64'd1);
      cyc();
    end
    bus.m1WE = 1'b0; bus.memAck = 1'b0;
    chk("t3_we_held", held, 64'd4);
    chk("t3_m1_readies", r1, 64'd1);
    chk("t3_m0_blocked", r0, 64'd0);
    @(negedge clk); chk("t3_gap_idle", bus.memRE, 64'd0);
    cyc();
    @(negedge clk);
    chk("t3_m0_granted", bus.memRE, 64'd1);
    chk("t3_m0_addr", bus.memAddr, 64'h42);
    cyc(); clr();

    // Watchdog: no acknowledge, abort on the 4th grant cycle
    do_reset();
    bus.m0RE = 1'b1; bus.memRead = 16'h1111;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("t4_no_err", bus.busErr, 64'd0);
      end else begin
        chk("t4_err", bus.busErr, 64'd1);
        chk("t4_ready", bus.m0Ready, 64'd1);
        chk("t4_rdata_zero", bus.m0RData, 64'd0);
      end
      cyc();
    end
    bus.m0RE = 1'b0;
    @(negedge clk); chk("t4_idle", bus.memRE, 64'd0);

    // Reset during the second cycle of a master 1 wait
    do_reset();
    bus.m1RE = 1'b1;
    cyc();
    cyc(); rst = 1'b1;
    @(negedge clk); chk("t5_still_grant", bus.memRE, 64'd1);
    cyc(); rst = 1'b0; bus.m0RE = 1'b1; bus.m0Addr = 32'h0000_0777; bus.m1Addr = 32'h0000_0888;
    @(negedge clk);
    chk("t5_idle_re", bus.memRE, 64'd0);
    chk("t5_no_ready", bus.m1Ready, 64'd0);
    cyc();
    @(negedge clk);
    chk("t5_m0_wins", bus.memAddr, 64'h777);
    cyc(); clr();

    // Locked master 1 against a competing master 0, memAck high
    do_reset();
    bus.m1RE = 1'b1; bus.m1Lock = 1'b1; bus.memAck = 1'b1; bus.m1Addr = 32'h0000_0900;
    cyc();
    bus.m0RE = 1'b1; bus.m0Addr = 32'h0000_0500;
    p0 = '0; p1 = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      p0[k] = bus.m0Ready; p1[k] = bus.m1Ready;
      cyc();
    end
    chk("t6_m1_pattern", p1, BURST_ON ? 10'b00_1111_1111 : 10'b01_0001_0001);
    chk("t6_m0_pattern", p0, BURST_ON ? 10'b10_0000_0000 : 10'b00_0100_0100);

    clr();
    cyc(); cyc();
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end
endmodule
